pwm_capture: RTL and testbench

- Input-capture peripheral that measures an external PWM waveform. It is the receive-side counterpart of the team's PWM generator.
- Reports period and high time in clk cycles, measured rising-edge to rising-edge.
- Sits next to the generator and is read through the same register front-end. It is also used for loopback self-test of the generator output.

---
 rtl/pwm_capture.sv | 144 ++++++++++++++
 tb/tb_pwm_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time (rising edge to rising edge) in clk cycles.
// Optional glitch filter between synchronizer and edge detector enabled by `define PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic             pwm_in,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             ovf,
    output logic             in_level,
    output logic             busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   lvl;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hi_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] filt_cnt;
    logic          filt;

    // The filtered level flips only on the FILT_LEN-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt     <= 1'b0;
            filt_cnt <= '0;
        end else if (s == filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt     <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign lvl = filt;
`else
    assign lvl = s;
`endif

    assign rise     = lvl & ~s_d;
    assign fall     = ~lvl & s_d;
    assign in_level = lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_d         <= 1'b0;
            cnt         <= '0;
            hi_lat      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            s_d        <= lvl;
            meas_valid <= 1'b0;
            if (ovf_clr) ovf <= 1'b0;

            // Disable dominates everything, including a coincident rise.
            if (!cap_en) begin
                state  <= IDLE;
                busy   <= 1'b0;
                cnt    <= '0;
                hi_lat <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                    ARM: begin
                        if (rise) begin
                            state  <= MEASURE;
                            cnt    <= '0;
                            hi_lat <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            meas_period <= cnt + ONE;
                            meas_high   <= hi_lat;
                            meas_valid  <= 1'b1;
                            cnt         <= '0;
                            hi_lat      <= '0;
                        end else if (cnt == CNT_MAX) begin
                            ovf    <= 1'b1;
                            state  <= ARM;
                            cnt    <= '0;
                            hi_lat <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                            if (fall) hi_lat <= cnt + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed waveforms, expected results queued at drive
// time and compared whenever meas_valid pulses.
module tb_pwm_capture;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cap_en = 1'b0;
    logic         pwm_in = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] meas_period;
    logic [W-1:0] meas_high;
    logic         meas_valid;
    logic         ovf;
    logic         in_level;
    logic         busy;

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   v0;
    int   k;
    logic valid_prev = 1'b0;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(W), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cap_en(cap_en),
        .pwm_in(pwm_in),
        .ovf_clr(ovf_clr),
        .meas_period(meas_period),
        .meas_high(meas_high),
        .meas_valid(meas_valid),
        .ovf(ovf),
        .in_level(in_level),
        .busy(busy)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(logic lv, int n);
        pwm_in = lv;
        repeat (n) tick();
    endtask

    // One period starting with its rising edge; meas=1 queues the result its closing rise must produce.
    task automatic wave(int p, int h, bit meas);
        exp_t e;
        if (meas) begin
            e.p = p;
            e.h = h;
            exp_q.push_back(e);
        end
        seg(1'b1, h);
        seg(1'b0, p - h);
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            n_valid++;
            check("valid_single_cycle", valid_prev, 0);
            check("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                check("meas_period", meas_period, e_mon.p);
                check("meas_high", meas_high, e_mon.h);
            end
        end
        valid_prev = meas_valid;
    end

    initial begin
        // reset values
        #12;
        check("rst_period", meas_period, 0);
        check("rst_high", meas_high, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_level", in_level, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap_en = 1'b1;
        repeat (3) tick();
        check("busy_armed", busy, 1);

        // steady 100/30: first rise only arms
        repeat (5) wave(100, 30, 1'b1);
        check("valids_after_5_periods", n_valid, 4);

        // duty change, then minimum period
        repeat (2) wave(100, 75, 1'b1);
`ifndef PWM_CAP_FILTER_EN
        repeat (3) wave(2, 1, 1'b1);
`endif
        wave(100, 30, 1'b1);

        // input stuck high: closing result, then saturation
        v0 = n_valid;
        pwm_in = 1'b1;
        k = 0;
        while (k < 400 && !ovf) begin
            @(negedge clk);
            k++;
        end
        check("ovf_set", ovf, 1);
        check("ovf_not_early", (k >= 250 && k <= 270), 1);
        check("ovf_in_level", in_level, 1);
        check("ovf_busy_arm", busy, 1);
        check("ovf_hold_period", meas_period, 100);
        check("ovf_hold_high", meas_high, 30);
        check("ovf_one_result", n_valid, v0 + 1);

        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 0);

        // clear held across a new saturation: set must win
        seg(1'b0, 5);
        pwm_in = 1'b1;
        ovf_clr = 1'b1;
        k = 0;
        while (k < 400 && !ovf) begin
            @(negedge clk);
            k++;
        end
        ovf_clr = 1'b0;
        check("ovf_set_beats_clr", ovf, 1);
        repeat (2) @(negedge clk);
        check("ovf_sticky", ovf, 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        seg(1'b0, 10);
        check("ovf_cleared_again", ovf, 0);

        // cap_en dropped 50 cycles into a period
        wave(100, 30, 1'b1);
        wave(100, 30, 1'b1);
        seg(1'b1, 30);
        seg(1'b0, 20);
        cap_en = 1'b0;
        v0 = n_valid;
        repeat (3) @(negedge clk);
        check("dis_busy", busy, 0);
        check("dis_hold_period", meas_period, 100);
        check("dis_hold_high", meas_high, 30);
        #1;
        seg(1'b0, 50);
        repeat (2) wave(100, 30, 1'b0);
        check("dis_no_valid", n_valid, v0);
        check("dis_queue_empty", exp_q.size(), 0);

        // re-enable: first rise arms, second closes
        cap_en = 1'b1;
        seg(1'b0, 10);
        wave(100, 40, 1'b1);
        wave(60, 20, 1'b1);
        seg(1'b1, 20);
        check("reen_results", n_valid, v0 + 2);

        // async reset mid-measurement
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_period", meas_period, 0);
        check("arst_high", meas_high, 0);
        check("arst_valid", meas_valid, 0);
        check("arst_ovf", ovf, 0);
        check("arst_in_level", in_level, 0);
        check("arst_busy", busy, 0);
        pwm_in = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seg(1'b0, 5);
        wave(50, 10, 1'b1);
        wave(50, 10, 1'b1);

`ifdef PWM_CAP_FILTER_EN
        // 2-cycle glitches in both phases are rejected; a 5-cycle pulse passes
        wave(100, 30, 1'b1);
        begin
            exp_t e;
            e.p = 100;
            e.h = 30;
            exp_q.push_back(e);
            seg(1'b1, 30);
            seg(1'b0, 20);
            seg(1'b1, 2);
            seg(1'b0, 48);
            exp_q.push_back(e);
            seg(1'b1, 10);
            seg(1'b0, 2);
            seg(1'b1, 18);
            seg(1'b0, 70);
        end
        wave(100, 5, 1'b1);
`endif

        seg(1'b1, 12);
        check("all_results_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
